mmio_memory: RTL and testbench

- Parametrised successor to the CPU's unified word memory.
- Provides single-port RAM with 1-cycle registered-address read, plus a memory-mapped I/O window at the top of the address space.
- The I/O window holds a buffered byte transmit channel with valid/ready handshake, status and scratch registers, and a write-stall signal back to the CPU state machine.
- Replaces the simulation-only character output with synthesizable I/O.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mmio_memory.sv | 156 +++++++++++++++
 tb/tb_mmio_memory.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O window of mmio_memory:
// register offsets, TX_STATUS bit layout and the window size.
package mmio_pkg;

  localparam int unsigned IO_WINDOW_WORDS = 128;
  localparam int unsigned IO_OFS_W        = 7;

  localparam logic [IO_OFS_W-1:0] TX_DATA_OFS   = 7'd1;
  localparam logic [IO_OFS_W-1:0] TX_STATUS_OFS = 7'd2;
  localparam logic [IO_OFS_W-1:0] SCRATCH_OFS   = 7'd3;
  localparam logic [IO_OFS_W-1:0] CYCLE_OFS     = 7'd4;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_COUNT_LSB = 2;

  // Width of a FIFO occupancy count able to hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with circular pointers and an occupancy counter.
// A push while full is accepted only if a pop happens in the same cycle.
// A pop on an empty FIFO is ignored, so push+pop when empty just pushes.
module sync_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [count_width(DEPTH)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Handshake qualification, pointer advance and occupancy update.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Head word is forced to zero while empty so it is clean after reset.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    count_o = count_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/mmio_memory.sv
// Unified word memory with a memory-mapped I/O window at the top of the
// address space: single-port RAM (1-cycle read, old data on read-during-write),
// a buffered byte transmit channel, a status register and a scratch register.
// Optional: define MMIO_CYCLE_COUNTER_EN to add a free-running cycle counter
// at I/O offset 4 (clear-on-write); otherwise offset 4 is unmapped.
module mmio_memory
  import mmio_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 32640,
  parameter int unsigned WORD_SIZE  = 20,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned IO_BASE    = 'hff80,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_SIZE-1:0]  value_i,
  input  logic                  write_i,
  output logic [WORD_SIZE-1:0]  value_o,
  output logic                  stall_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i
);

  localparam int unsigned RAM_AW = $clog2(MEM_SIZE);
  localparam int unsigned CW     = count_width(TX_DEPTH);

  logic [WORD_SIZE-1:0]  ram_q [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] latched_addr_q, latched_addr_d;
  logic [WORD_SIZE-1:0]  io_rdata_q, io_rdata_d;
  logic [WORD_SIZE-1:0]  scratch_q, scratch_d;
  logic                  rdw_q, rdw_d;
  logic [WORD_SIZE-1:0]  rdw_old_q, rdw_old_d;

  logic                  ram_hit, io_hit, latched_ram;
  logic [IO_OFS_W-1:0]   io_ofs;
  logic                  ram_we, tx_write, tx_push, tx_pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [WORD_SIZE-1:0]  status;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [WORD_SIZE-1:0]  cycle_q, cycle_d;
`endif

  // Address decode and transmit handshake / stall generation.
  always_comb begin
    ram_hit    = 32'(addr_i) < MEM_SIZE;
    io_hit     = (32'(addr_i) >= IO_BASE) && (32'(addr_i) < IO_BASE + IO_WINDOW_WORDS);
    io_ofs     = IO_OFS_W'(addr_i - IO_BASE[ADDR_WIDTH-1:0]);
    tx_valid_o = !fifo_empty;
    tx_pop     = tx_valid_o && tx_ready_i;
    tx_write   = write_i && io_hit && (io_ofs == TX_DATA_OFS);
    stall_o    = tx_write && fifo_full && !tx_pop;
    tx_push    = tx_write && !stall_o;
    ram_we     = write_i && ram_hit;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (tx_push),
    .data_i  (value_i[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  // Free-running cycle counter, cleared by any write to its offset.
  always_comb begin
    if (write_i && io_hit && (io_ofs == CYCLE_OFS)) cycle_d = '0;
    else                                            cycle_d = cycle_q + WORD_SIZE'(1);
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end
`endif

  // Next-state for read address, I/O read data, scratch and RDW capture.
  always_comb begin
    status                          = '0;
    status[STAT_FULL_BIT]           = fifo_full;
    status[STAT_EMPTY_BIT]          = fifo_empty;
    status[STAT_COUNT_LSB +: CW]    = fifo_count;

    latched_addr_d = addr_i;
    scratch_d      = scratch_q;
    io_rdata_d     = '0;
    if (io_hit) begin
      case (io_ofs)
        TX_STATUS_OFS: io_rdata_d = status;
        SCRATCH_OFS:   io_rdata_d = scratch_q;
`ifdef MMIO_CYCLE_COUNTER_EN
        CYCLE_OFS:     io_rdata_d = cycle_d;
`endif
        default:       io_rdata_d = '0;
      endcase
      if (write_i && (io_ofs == SCRATCH_OFS)) scratch_d = value_i;
    end

    // The RAM is read combinationally from the latched address, so a write
    // to that same address would show new data; keep the pre-write word.
    rdw_d     = ram_we;
    rdw_old_d = ram_q[addr_i[RAM_AW-1:0]];

    // A stalled write freezes everything but the FIFO pop side.
    if (stall_o) begin
      latched_addr_d = latched_addr_q;
      io_rdata_d     = io_rdata_q;
      rdw_d          = rdw_q;
      rdw_old_d      = rdw_old_q;
    end
  end

  // Read-path and I/O register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latched_addr_q <= '0;
      io_rdata_q     <= '0;
      scratch_q      <= '0;
      rdw_q          <= 1'b0;
      rdw_old_q      <= '0;
    end else begin
      latched_addr_q <= latched_addr_d;
      io_rdata_q     <= io_rdata_d;
      scratch_q      <= scratch_d;
      rdw_q          <= rdw_d;
      rdw_old_q      <= rdw_old_d;
    end
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[addr_i[RAM_AW-1:0]] <= value_i;
  end

  // Read data mux: RAM word at the latched address, else captured I/O data.
  always_comb begin
    latched_ram = 32'(latched_addr_q) < MEM_SIZE;
    if (latched_ram) value_o = rdw_q ? rdw_old_q : ram_q[latched_addr_q[RAM_AW-1:0]];
    else             value_o = io_rdata_q;
  end

endmodule

// File: tb/tb_mmio_memory.sv
// Directed self-checking bench for mmio_memory.
module tb_mmio_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_i;
  logic [19:0] value_i;
  logic        write_i;
  logic [19:0] value_o;
  logic        stall_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  int n_vec = 0;
  int n_err = 0;

  mmio_memory #(
    .MEM_SIZE   (32640),
    .WORD_SIZE  (20),
    .ADDR_WIDTH (16),
    .IO_BASE    ('hff80),
    .TX_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_i     (addr_i),
    .value_i    (value_i),
    .write_i    (write_i),
    .value_o    (value_o),
    .stall_o    (stall_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [19:0] v);
    addr_i = a; value_i = v; write_i = 1'b1;
    tick();
    write_i = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    addr_i = a; write_i = 1'b0;
    tick();
  endtask

  logic [19:0] c1, c2;

  initial begin
    reset = 1'b1; addr_i = '0; value_i = '0; write_i = 1'b0; tx_ready_i = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", 32'(tx_valid_o), 0);
    chk("rst_tx_data",  32'(tx_data_o), 0);
    chk("rst_stall",    32'(stall_o), 0);
    #2 reset = 1'b0;

    // RAM round trip and read-during-write
    wr(16'd100, 20'h3abcd);
    rd(16'd100);
    chk("ram_rd_100", 32'(value_o), 'h3abcd);
    wr(16'd101, 20'h11111);
    wr(16'd101, 20'h22222);
    chk("ram_rdw_old", 32'(value_o), 'h11111);
    rd(16'd101);
    chk("ram_rd_101", 32'(value_o), 'h22222);

    // Hole
    wr(16'd32700, 20'h12345);
    rd(16'd32700);
    chk("hole_rd", 32'(value_o), 0);
    rd(16'd100);
    chk("ram_keep_100", 32'(value_o), 'h3abcd);
    rd(16'hff81);
    chk("txdata_rd0", 32'(value_o), 0);
    rd(16'hff90);
    chk("unmapped_rd0", 32'(value_o), 0);

    // FIFO fill and stall
    tx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr_i = 16'hff81; value_i = 20'(32'h41 + i); write_i = 1'b1;
      #1 chk("fill_nostall", 32'(stall_o), 0);
      tick();
    end
    write_i = 1'b0;
    rd(16'hff82);
    chk("status_full", 32'(value_o), 'h21);
    chk("full_valid", 32'(tx_valid_o), 1);
    chk("full_head", 32'(tx_data_o), 'h41);
    addr_i = 16'hff81; value_i = 20'h49; write_i = 1'b1;
    #1 chk("stall_on", 32'(stall_o), 1);
    tick();
    chk("stall_held", 32'(stall_o), 1);
    chk("stall_head", 32'(tx_data_o), 'h41);
    tx_ready_i = 1'b1;
    #1 chk("stall_release", 32'(stall_o), 0);
    tick();
    write_i = 1'b0; tx_ready_i = 1'b0;
    chk("after_stall_head", 32'(tx_data_o), 'h42);
    rd(16'hff82);
    chk("status_full2", 32'(value_o), 'h21);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain1", 32'(tx_data_o), 32'h42 + i);
      tick();
    end
    tx_ready_i = 1'b0;
    chk("drain1_empty", 32'(tx_valid_o), 0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 8; i++) wr(16'hff81, 20'(32'h50 + i));
    addr_i = 16'hff81; value_i = 20'h5a; write_i = 1'b1; tx_ready_i = 1'b1;
    #1 chk("pp_nostall", 32'(stall_o), 0);
    chk("pp_oldest", 32'(tx_data_o), 'h50);
    tick();
    write_i = 1'b0; tx_ready_i = 1'b0;
    rd(16'hff82);
    chk("pp_status", 32'(value_o), 'h21);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("drain2", 32'(tx_data_o), 32'h51 + i);
      tick();
    end
    chk("drain2_last", 32'(tx_data_o), 'h5a);
    tick();
    chk("drain2_empty", 32'(tx_valid_o), 0);

    // Push into empty FIFO with consumer ready: no fall-through
    addr_i = 16'hff81; value_i = 20'h30; write_i = 1'b1;
    #1 chk("ep_no_fallthru", 32'(tx_valid_o), 0);
    tick();
    write_i = 1'b0;
    chk("ep_valid", 32'(tx_valid_o), 1);
    chk("ep_data", 32'(tx_data_o), 'h30);
    tick();
    chk("ep_popped", 32'(tx_valid_o), 0);
    tx_ready_i = 1'b0;
    rd(16'hff82);
    chk("ep_status", 32'(value_o), 'h02);

    // Reset mid-operation
    wr(16'hff83, 20'h12345);
    wr(16'hff81, 20'h61);
    wr(16'hff81, 20'h62);
    wr(16'hff81, 20'h63);
    rd(16'hff83);
    chk("scratch_rd", 32'(value_o), 'h12345);
    rd(16'hff82);
    chk("status_cnt3", 32'(value_o), 'h0c);
    #2 reset = 1'b1;
    #1 chk("arst_valid", 32'(tx_valid_o), 0);
    chk("arst_data", 32'(tx_data_o), 0);
    #2 reset = 1'b0;
    rd(16'hff82);
    chk("post_rst_status", 32'(value_o), 'h02);
    rd(16'hff83);
    chk("post_rst_scratch", 32'(value_o), 0);

    // Cycle counter offset
`ifdef MMIO_CYCLE_COUNTER_EN
    rd(16'hff84);
    c1 = value_o;
    repeat (10) tick();
    c2 = value_o;
    chk("cycle_delta", 32'(c2 - c1), 10);
    wr(16'hff84, 20'h0);
    rd(16'hff84);
    chk("cycle_clear", 32'(value_o), 1);
`else
    c1 = '0; c2 = '0;
    wr(16'hff84, 20'h777);
    rd(16'hff84);
    chk("cycle_absent", 32'(value_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
